// File: rtl/pe_serial_tx_if.sv
// Load handshake between an upstream producer and the pe_serial_tx transmitter.
// The producer drives load_valid/load_data; the transmitter answers with load_ready.
interface pe_serial_tx_if #(
   parameter int WIDTH = 8
);
   logic             load_valid;
   logic [WIDTH-1:0] load_data;
   logic             load_ready;

   modport master (output load_valid, output load_data, input load_ready);
   modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/pe_serial_tx.sv
// Bit-serial transmitter: takes a parallel word over a valid/ready handshake and
// shifts it out one bit per clock with a frame strobe, then pulses done for one cycle.
module pe_serial_tx #(
   parameter int WIDTH      = 8,
   parameter bit LSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   pe_serial_tx_if.slave ld,
   output logic          ser_out,
   output logic          ser_frame,
   output logic          busy,
   output logic          done
);
   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] shreg_r;
   logic [CW-1:0]    cnt_r;
   logic             ser_out_r;
   logic             ser_frame_r;
   logic             busy_r;
   logic             done_r;
   logic             load_ready_r;

   logic [WIDTH-1:0] shreg_adv_s;
   logic             next_bit_s;
   logic             first_bit_s;

   // Shift direction and the bit that goes out next, for both bit orders.
   always_comb begin
      shreg_adv_s = shreg_r;
      next_bit_s  = 1'b0;
      first_bit_s = 1'b0;
      if (LSB_FIRST) begin
         shreg_adv_s = {1'b0, shreg_r[WIDTH-1:1]};
         next_bit_s  = shreg_r[1];
         first_bit_s = ld.load_data[0];
      end else begin
         shreg_adv_s = {shreg_r[WIDTH-2:0], 1'b0};
         next_bit_s  = shreg_r[WIDTH-2];
         first_bit_s = ld.load_data[WIDTH-1];
      end
   end

   // Transmit FSM; every output is a register so nothing combinational reaches a port.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         shreg_r      <= '0;
         cnt_r        <= '0;
         ser_out_r    <= IDLE_LEVEL;
         ser_frame_r  <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         load_ready_r <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (ld.load_valid && load_ready_r) begin
                  // First bit is launched on the accept edge itself for one-cycle latency.
                  state_r      <= ST_SHIFT;
                  shreg_r      <= ld.load_data;
                  cnt_r        <= '0;
                  ser_out_r    <= first_bit_s;
                  ser_frame_r  <= 1'b1;
                  busy_r       <= 1'b1;
                  load_ready_r <= 1'b0;
               end else begin
                  ser_out_r    <= IDLE_LEVEL;
                  ser_frame_r  <= 1'b0;
                  busy_r       <= 1'b0;
                  load_ready_r <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (cnt_r == LAST_BIT) begin
                  state_r     <= ST_DONE;
                  ser_out_r   <= IDLE_LEVEL;
                  ser_frame_r <= 1'b0;
                  done_r      <= 1'b1;
               end else begin
                  shreg_r   <= shreg_adv_s;
                  cnt_r     <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                  ser_out_r <= next_bit_s;
               end
            end
            ST_DONE: begin
               state_r      <= ST_IDLE;
               done_r       <= 1'b0;
               busy_r       <= 1'b0;
               load_ready_r <= 1'b1;
            end
            default: begin
               state_r      <= ST_IDLE;
               ser_out_r    <= IDLE_LEVEL;
               ser_frame_r  <= 1'b0;
               busy_r       <= 1'b0;
               done_r       <= 1'b0;
               load_ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign ser_out       = ser_out_r;
   assign ser_frame     = ser_frame_r;
   assign busy          = busy_r;
   assign done          = done_r;
   assign ld.load_ready = load_ready_r;
endmodule

// File: tb/tb_pe_serial_tx.sv
// Directed bench: one LSB-first/idle-high and one MSB-first/idle-low transmitter
// driven with identical stimulus, each feeding a downstream flip-flop chain.
module tb_pe_serial_tx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   pe_serial_tx_if #(.WIDTH(8)) if_a ();
   pe_serial_tx_if #(.WIDTH(8)) if_b ();

   logic ser_a, frame_a, busy_a, done_a;
   logic ser_b, frame_b, busy_b, done_b;
   logic [7:0] chain_a = 8'h00;
   logic [7:0] chain_b = 8'h00;

   pe_serial_tx #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_a (
      .clk(clk), .rst(rst), .ld(if_a),
      .ser_out(ser_a), .ser_frame(frame_a), .busy(busy_a), .done(done_a)
   );
   pe_serial_tx #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
      .clk(clk), .rst(rst), .ld(if_b),
      .ser_out(ser_b), .ser_frame(frame_b), .busy(busy_b), .done(done_b)
   );

   always #5 clk = ~clk;

   // Downstream receivers: LSB-first fills from the top, MSB-first from the bottom.
   always @(posedge clk) begin
      if (frame_a) chain_a <= {ser_a, chain_a[7:1]};
      if (frame_b) chain_b <= {chain_b[6:0], ser_b};
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] d);
      if_a.load_valid = v; if_a.load_data = d;
      if_b.load_valid = v; if_b.load_data = d;
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, " frame_a"}, 32'(frame_a), 32'd0);
      check_eq({tag, " frame_b"}, 32'(frame_b), 32'd0);
      check_eq({tag, " ser_a"},   32'(ser_a),   32'd1);
      check_eq({tag, " ser_b"},   32'(ser_b),   32'd0);
      check_eq({tag, " busy"},    32'({busy_a, busy_b}), 32'd0);
      check_eq({tag, " done"},    32'({done_a, done_b}), 32'd0);
      check_eq({tag, " ready"},   32'({if_a.load_ready, if_b.load_ready}), 32'd3);
   endtask

   // Called at a negedge with both blocks idle; seq_x[k] is the k-th bit on the wire.
   task automatic run_frame(input string tag, input logic [7:0] d,
                            input logic [7:0] seq_a, input logic [7:0] seq_b);
      drive(1'b1, d);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) drive(1'b0, ~d);
         check_eq($sformatf("%s bit%0d ser_a", tag, k), 32'(ser_a), 32'(seq_a[k]));
         check_eq($sformatf("%s bit%0d ser_b", tag, k), 32'(ser_b), 32'(seq_b[k]));
         check_eq($sformatf("%s bit%0d frame", tag, k), 32'({frame_a, frame_b}), 32'd3);
         check_eq($sformatf("%s bit%0d busy/ready", tag, k),
                  32'({busy_a, busy_b, if_a.load_ready, if_b.load_ready}), 32'hC);
      end
      @(negedge clk);
      check_eq({tag, " done"},      32'({done_a, done_b}), 32'd3);
      check_eq({tag, " done frame"}, 32'({frame_a, frame_b}), 32'd0);
      check_eq({tag, " done ser"},  32'({ser_a, ser_b}), 32'd2);
      check_eq({tag, " done busy/ready"},
               32'({busy_a, busy_b, if_a.load_ready, if_b.load_ready}), 32'hC);
      @(negedge clk);
      check_idle({tag, " after"});
      check_eq({tag, " chain_a"}, 32'(chain_a), 32'(d));
      check_eq({tag, " chain_b"}, 32'(chain_b), 32'(d));
   endtask

   logic [19:0] exp_frame, exp_done, exp_ready, exp_ser_a, exp_ser_b;

   initial begin
      drive(1'b0, 8'h00);
      rst = 1'b1;
      @(negedge clk);
      check_idle("reset1");
      @(negedge clk);
      check_idle("reset2");
      rst = 1'b0;
      @(negedge clk);
      check_idle("post reset");

      run_frame("c1", 8'hC1, 8'hC1, 8'h83);

      // Back-to-back: 0F then F0 with valid held; data wiggles while word 1 is in flight.
      exp_frame = 20'h3FCFF;
      exp_done  = 20'h40100;
      exp_ready = 20'h80200;
      exp_ser_a = 20'hFC30F;
      exp_ser_b = 20'h03CF0;
      drive(1'b1, 8'h0F);
      for (int j = 1; j <= 20; j++) begin
         @(negedge clk);
         check_eq($sformatf("b2b j%0d frame_a", j), 32'(frame_a), 32'(exp_frame[j-1]));
         check_eq($sformatf("b2b j%0d frame_b", j), 32'(frame_b), 32'(exp_frame[j-1]));
         check_eq($sformatf("b2b j%0d done", j), 32'(done_a), 32'(exp_done[j-1]));
         check_eq($sformatf("b2b j%0d ready", j), 32'(if_b.load_ready), 32'(exp_ready[j-1]));
         check_eq($sformatf("b2b j%0d ser_a", j), 32'(ser_a), 32'(exp_ser_a[j-1]));
         check_eq($sformatf("b2b j%0d ser_b", j), 32'(ser_b), 32'(exp_ser_b[j-1]));
         if (j <= 5)       drive(1'b1, 8'hAA);
         else if (j <= 10) drive(1'b1, 8'hF0);
         else              drive(1'b0, 8'h00);
      end
      check_eq("b2b chain_a", 32'(chain_a), 32'h0000_00F0);
      check_eq("b2b chain_b", 32'(chain_b), 32'h0000_00F0);

      // Reset lands on the edge closing the 4th data bit of 8'hFF.
      drive(1'b1, 8'hFF);
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         if (j == 1) drive(1'b0, 8'h00);
         check_eq($sformatf("abort j%0d frame", j), 32'({frame_a, frame_b}), 32'd3);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("abort");
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         check_eq($sformatf("abort quiet%0d", j), 32'({done_a, done_b, frame_a, frame_b}), 32'd0);
      end
      run_frame("96", 8'h96, 8'h96, 8'h69);

      // Reset and load on the same edge: the word waits for the first edge without reset.
      rst = 1'b1;
      drive(1'b1, 8'h5A);
      @(negedge clk);
      check_idle("collide");
      rst = 1'b0;
      run_frame("5a", 8'h5A, 8'h5A, 8'h5A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
